// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for the stream FIFO read-side blocks.
package stream_fifo_pkg;

   // Occupancy of the two-entry output stage; OCC_BAD is unreachable and recovers to empty.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2,
      OCC_BAD   = 2'd3
   } occ_t;

   // Width of a level count covering FIFO words, the FWFT head and the output stage.
   function automatic int unsigned level_width(input int unsigned addrwidth);
      return addrwidth + 2;
   endfunction

endpackage

// File: rtl/stream_skid_reg.sv
// Generic two-entry valid/ready skid register: registered outputs, s_ready free of m_ready.
module stream_skid_reg
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DWIDTH-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output occ_t              occ
);

   occ_t              state;
   occ_t              state_next;
   logic              push;
   logic              pop;
   logic              load_head_in;
   logic              load_head_skid;
   logic              load_skid;
   logic [DWIDTH-1:0] head;
   logic [DWIDTH-1:0] skid;

   assign push = s_valid && s_ready;
   assign pop  = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OCC_EMPTY;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         OCC_EMPTY: if (push) state_next = OCC_ONE;
         OCC_ONE: begin
            if (push && !pop)      state_next = OCC_FULL;
            else if (!push && pop) state_next = OCC_EMPTY;
         end
         OCC_FULL:  if (pop) state_next = OCC_ONE;
         default:   state_next = OCC_EMPTY;
      endcase
   end

   always_comb begin
      m_valid        = (state != OCC_EMPTY);
      s_ready        = (state != OCC_FULL);
      load_head_in   = push && ((state == OCC_EMPTY) || ((state == OCC_ONE) && pop));
      load_head_skid = (state == OCC_FULL) && pop;
      load_skid      = push && (state == OCC_ONE) && !pop;
   end

   // The skid word is always younger than the head, so it refills the head on a FULL pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         skid <= '0;
      end else begin
         if (load_head_in)        head <= s_data;
         else if (load_head_skid) head <= skid;
         if (load_skid)           skid <= s_data;
      end
   end

   assign m_data = head;
   assign occ    = state;

endmodule

// File: rtl/stream_asyn_fifo_rd_skid.sv
// Read-domain output stage: pops the FWFT head into a skid register and reports the readable level.
module stream_asyn_fifo_rd_skid
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned ADDRWIDTH = 6
) (
   input  logic                                r_clk,
   input  logic                                r_rst_n,
   input  logic                                r_valid,
   input  logic [DWIDTH-1:0]                   r_dout,
   input  logic [ADDRWIDTH:0]                  r_counter,
   output logic                                r_en,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [DWIDTH-1:0]                   m_data,
   output logic [level_width(ADDRWIDTH)-1:0]   m_level
);

   localparam int unsigned LW = level_width(ADDRWIDTH);

   logic ready;
   occ_t occ;

   stream_skid_reg #(
      .DWIDTH (DWIDTH)
   ) u_skid (
      .clk     (r_clk),
      .rst_n   (r_rst_n),
      .s_valid (r_valid),
      .s_ready (ready),
      .s_data  (r_dout),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .occ     (occ)
   );

   assign r_en    = r_valid && ready;
   assign m_level = LW'(r_counter) + LW'(r_valid) + LW'(occ);

endmodule
